// File: rtl/modn_counter_pkg.sv
// Shared definitions for the modulo-N counter primitive of the ADS1675
// capture path: the counter-width helper and the standard moduli.
package modn_counter_pkg;

  // Frame period at 2 MSPS, in sclk cycles.
  localparam int FRAME_2M  = 48;
  // Frame period at 4 MSPS, in sclk cycles.
  localparam int FRAME_4M  = 24;
  // DRDY pulse width, in sclk cycles.
  localparam int DRDY_W    = 3;
  // Bits per conversion word on the serial interface.
  localparam int WORD_BITS = 24;

  // Width needed to hold 0..n-1. It is never below one bit, so N=1 still
  // gets a real (constant-zero) count port.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modn_counter.sv
// Modulo-N enable counter with a combinational terminal-count strobe.
// Reset (areset_n) is synchronous and active-low, so it may be driven from
// logic, e.g. ~co of another counter, to chain counters into pulses/windows.
// IS_NEGEDGE selects the active sclk edge for every flop.
// Optional build macro: MODN_COUNTER_SVA_EN compiles in protocol assertions.
module modn_counter
  import modn_counter_pkg::*;
#(
  parameter int N          = WORD_BITS,
  parameter bit IS_NEGEDGE = 1'b0
) (
  input  logic                    sclk,
  input  logic                    areset_n,
  input  logic                    en,
  output logic                    co,
  output logic [cnt_width(N)-1:0] cnt
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          at_last;
  logic [CW-1:0] cnt_next;

  assign at_last = (cnt == LAST);

  // The strobe reflects the registered count and en in the same cycle; it is
  // deliberately not gated by areset_n, the instantiating block owns that.
  assign co = en & at_last;

  // Next-count selection: wrap at the terminal value, advance when enabled.
  always_comb begin
    // NOTE: default first, so every path assigns cnt_next and no latch forms.
    cnt_next = cnt;
    if (en) begin
      cnt_next = at_last ? '0 : cnt + 1'b1;
    end
  end

  if (IS_NEGEDGE) begin : g_negedge
    // Count register on the falling edge; reset takes priority over en.
    always_ff @(negedge sclk) begin
      // NOTE: non-blocking assignment, so every flop samples pre-edge values.
      if (!areset_n) cnt <= '0;
      else           cnt <= cnt_next;
    end
  end else begin : g_posedge
    // Count register on the rising edge; reset takes priority over en.
    always_ff @(posedge sclk) begin
      if (!areset_n) cnt <= '0;
      else           cnt <= cnt_next;
    end
  end

`ifdef MODN_COUNTER_SVA_EN
  if (N < 1) begin : g_bad_modulus
    $error("modn_counter: modulus N must be at least 1");
  end

  logic sva_clk;
  assign sva_clk = IS_NEGEDGE ? ~sclk : sclk;

  a_cnt_in_range: assert property (
    @(posedge sva_clk) disable iff (!areset_n) 32'(cnt) < N);

  a_co_at_last: assert property (
    @(posedge sva_clk) disable iff (!areset_n) co |-> (cnt == LAST));

  a_advance_by_one: assert property (
    @(posedge sva_clk) disable iff (!areset_n)
    (en && !co) |=> (cnt == $past(cnt) + 1'b1));
`endif

endmodule

// File: tb/tb_modn_counter.sv
// Self-checking bench for modn_counter: a free-running N=48 counter chained
// into an N=3 counter, a falling-edge N=24 window counter, an N=5 counter
// driven from a vector table, and the degenerate N=1 case.
module tb_modn_counter;

  typedef struct {
    logic       en;
    logic       exp_co;
    logic [2:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // N=48 frame counter and N=3 counter reset by its strobe.
  logic       rst48, en48, co48, co3;
  logic [5:0] cnt48;
  logic [1:0] cnt3;
  logic       rst3;
  assign rst3 = rst48 & ~co48;

  // N=24 falling-edge window counter, enable and reset both from mask.
  logic       mask, co24;
  logic [4:0] cnt24;

  // N=5 general counter and N=1 degenerate counter.
  logic       rst5, en5, co5;
  logic [2:0] cnt5;
  logic       rst1, en1, co1;
  logic [0:0] cnt1;

  modn_counter #(.N(48)) u_c48 (
    .sclk(clk), .areset_n(rst48), .en(en48), .co(co48), .cnt(cnt48));
  modn_counter #(.N(3)) u_c3 (
    .sclk(clk), .areset_n(rst3), .en(1'b1), .co(co3), .cnt(cnt3));
  modn_counter #(.N(24), .IS_NEGEDGE(1'b1)) u_c24 (
    .sclk(clk), .areset_n(mask), .en(mask), .co(co24), .cnt(cnt24));
  modn_counter #(.N(5)) u_c5 (
    .sclk(clk), .areset_n(rst5), .en(en5), .co(co5), .cnt(cnt5));
  modn_counter #(.N(1)) u_c1 (
    .sclk(clk), .areset_n(rst1), .en(en1), .co(co1), .cnt(cnt1));

  // DRDY-style flag: set by the frame strobe, cleared by the width strobe.
  // The window spans the co48 cycle through the co3 cycle inclusive.
  logic flag_q = 1'b0;
  logic window;
  always @(posedge clk) begin
    if (co48)     flag_q <= 1'b1;
    else if (co3) flag_q <= 1'b0;
  end
  assign window = co48 | flag_q;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vec5 [13];
    vec_t vec1 [6];
    int   win_cycles;

    // N=5: en 1,0,1,1,0,1,1 then a run that idles at the terminal count.
    vec5[0]  = '{1'b1, 1'b0, 3'd1};
    vec5[1]  = '{1'b0, 1'b0, 3'd1};
    vec5[2]  = '{1'b1, 1'b0, 3'd2};
    vec5[3]  = '{1'b1, 1'b0, 3'd3};
    vec5[4]  = '{1'b0, 1'b0, 3'd3};
    vec5[5]  = '{1'b1, 1'b0, 3'd4};
    vec5[6]  = '{1'b1, 1'b1, 3'd0};
    vec5[7]  = '{1'b1, 1'b0, 3'd1};
    vec5[8]  = '{1'b1, 1'b0, 3'd2};
    vec5[9]  = '{1'b1, 1'b0, 3'd3};
    vec5[10] = '{1'b1, 1'b0, 3'd4};
    vec5[11] = '{1'b0, 1'b0, 3'd4};
    vec5[12] = '{1'b1, 1'b1, 3'd0};

    // N=1: co follows en, count stays zero.
    vec1[0] = '{1'b1, 1'b1, 3'd0};
    vec1[1] = '{1'b0, 1'b0, 3'd0};
    vec1[2] = '{1'b1, 1'b1, 3'd0};
    vec1[3] = '{1'b1, 1'b1, 3'd0};
    vec1[4] = '{1'b0, 1'b0, 3'd0};
    vec1[5] = '{1'b1, 1'b1, 3'd0};

    rst48 = 1'b0; en48 = 1'b1;
    mask  = 1'b0;
    rst5  = 1'b0; en5  = 1'b1;
    rst1  = 1'b0; en1  = 1'b1;

    // Reset state, with enables high to show reset wins.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cnt48", 32'(cnt48), 32'd0);
    check("rst_co48",  32'(co48),  32'd0);
    check("rst_cnt24", 32'(cnt24), 32'd0);
    check("rst_co24",  32'(co24),  32'd0);
    check("rst_cnt5",  32'(cnt5),  32'd0);
    check("rst_co5",   32'(co5),   32'd0);
    check("rst_cnt1",  32'(cnt1),  32'd0);
    check("rst_co1_en_high", 32'(co1), 32'd1);

    // N=48 free run with the chained N=3 pulse-width counter.
    @(posedge clk); #1;
    rst48 = 1'b1;
    win_cycles = 0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      check($sformatf("co48_c%0d", c), 32'(co48), 32'(c % 48 == 0));
      if (c % 48 == 0 || c % 48 == 1)
        check($sformatf("cnt48_c%0d", c), 32'(cnt48), 32'((c - 1) % 48));
      if (c == 51) check("window_last_c51",  32'(window), 32'd1);
      if (c == 52) check("window_clear_c52", 32'(window), 32'd0);
      if (window) win_cycles++;
    end
    check("window_cycles_3_frames", 32'(win_cycles), 32'd12);

    // Dropping en mid-count freezes the count and silences co.
    en48 = 1'b0;
    repeat (3) @(negedge clk);
    check("cnt48_hold_en_low", 32'(cnt48), 32'd5);
    check("co48_en_low",       32'(co48),  32'd0);

    // N=24 falling-edge window: mask raises, co drops mask on the 24th edge.
    @(posedge clk); #1;
    mask = 1'b1;
    check("cnt24_mask_rise", 32'(cnt24), 32'd0);
    for (int j = 1; j <= 23; j++) begin
      @(posedge clk); #1;
      check($sformatf("cnt24_fe%0d", j), 32'(cnt24), 32'(j));
      check($sformatf("co24_fe%0d", j),  32'(co24),  32'(j == 23));
    end
    @(negedge clk); #1;
    mask = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("cnt24_after_window", 32'(cnt24), 32'd0);
      check("co24_after_window",  32'(co24),  32'd0);
    end

    // N=5 table: co sampled before each edge, count after it.
    rst5 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      en5 = vec5[i].en;
      @(negedge clk);
      check($sformatf("co5_v%0d", i), 32'(co5), 32'(vec5[i].exp_co));
      @(posedge clk); #1;
      check($sformatf("cnt5_v%0d", i), 32'(cnt5), 32'(vec5[i].exp_cnt));
    end

    // N=5 mid-count reset with en high discards the partial count.
    en5 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("cnt5_before_reset", 32'(cnt5), 32'd3);
    rst5 = 1'b0;
    @(posedge clk); #1;
    check("cnt5_reset_over_en", 32'(cnt5), 32'd0);
    rst5 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("co5_post_reset_k%0d", k), 32'(co5), 32'(k == 5));
      @(posedge clk); #1;
    end
    check("cnt5_post_reset_wrap", 32'(cnt5), 32'd0);

    // N=1 table.
    rst1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en1 = vec1[i].en;
      @(negedge clk);
      check($sformatf("co1_v%0d", i),  32'(co1),  32'(vec1[i].exp_co));
      check($sformatf("cnt1_v%0d", i), 32'(cnt1), 32'(vec1[i].exp_cnt));
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
